// File: rtl/seat_manager_if.sv
// Request/response bus of the seat manager.
// Handshake: a beat transfers on a rising edge where valid & ready are both high; the sender keeps its payload stable while valid is high and ready is low.
interface seat_manager_if #(
    parameter int NUM_SEATS = 32,
    parameter int ID_WIDTH  = 25
);
    localparam int SEAT_W = $clog2(NUM_SEATS);

    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_op;
    logic [ID_WIDTH-1:0] req_student;
    logic [SEAT_W-1:0]   req_seat;

    logic                resp_valid;
    logic                resp_ready;
    logic [2:0]          resp_status;
    logic [1:0]          resp_state;
    logic [ID_WIDTH-1:0] resp_owner;

    modport slave (
        input  req_valid, req_op, req_student, req_seat, resp_ready,
        output req_ready, resp_valid, resp_status, resp_state, resp_owner
    );

    modport master (
        output req_valid, req_op, req_student, req_seat, resp_ready,
        input  req_ready, resp_valid, resp_status, resp_state, resp_owner
    );
endinterface

// File: rtl/seat_manager.sv
// Seat table with per-seat state/owner/timer, one command in and one response out per cycle.
// Define SEAT_FORCE_EN to enable op 6 FORCE_RELEASE; otherwise op 6 answers ERR_OP.
module seat_manager #(
    parameter int NUM_SEATS       = 32,
    parameter int ID_WIDTH        = 25,
    parameter int RESERVE_TIMEOUT = 10,
    parameter int AWAY_TIMEOUT    = 20
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             tick,
    seat_manager_if.slave                    bus,
    output logic                             expire_valid,
    output logic [$clog2(NUM_SEATS+1)-1:0]   occupied_count
);
    localparam int SEAT_W  = $clog2(NUM_SEATS);
    localparam int CNT_W   = $clog2(NUM_SEATS + 1);
    localparam int TMR_MAX = (RESERVE_TIMEOUT > AWAY_TIMEOUT) ? RESERVE_TIMEOUT : AWAY_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [SEAT_W:0]  SEAT_LIM = (SEAT_W + 1)'(NUM_SEATS);
    localparam logic [TMR_W-1:0] RES_T    = TMR_W'(RESERVE_TIMEOUT);
    localparam logic [TMR_W-1:0] AWAY_T   = TMR_W'(AWAY_TIMEOUT);

    localparam logic [2:0] OP_RESERVE = 3'd0, OP_CHECKIN = 3'd1, OP_AWAY  = 3'd2,
                           OP_RETURN  = 3'd3, OP_RELEASE = 3'd4, OP_QUERY = 3'd5,
                           OP_FORCE   = 3'd6, OP_RSVD    = 3'd7;

    typedef enum logic [1:0] {EMPTY = 2'b00, RESERVED = 2'b01, AWAY = 2'b10, OCCUPIED = 2'b11} seat_state_t;
    typedef enum logic [2:0] {ST_OK = 3'd0, ST_ERR_SEAT = 3'd1, ST_ERR_STATE = 3'd2,
                              ST_ERR_OWNER = 3'd3, ST_ERR_BUSY = 3'd4, ST_ERR_OP = 3'd5} status_t;

    seat_state_t         state_q [NUM_SEATS];
    seat_state_t         state_d [NUM_SEATS];
    logic [ID_WIDTH-1:0] owner_q [NUM_SEATS];
    logic [ID_WIDTH-1:0] owner_d [NUM_SEATS];
    logic [TMR_W-1:0]    timer_q [NUM_SEATS];
    logic [TMR_W-1:0]    timer_d [NUM_SEATS];

    logic [NUM_SEATS-1:0] expiring;
    logic                 expire_any;
    logic                 owns_any;
    logic                 accept;
    logic                 seat_ok;
    logic                 op_legal;
    logic [SEAT_W-1:0]    sel;
    seat_state_t          cur_state;
    logic [ID_WIDTH-1:0]  cur_owner;
    logic                 owner_match;
    logic                 wr;
    seat_state_t          new_state;
    logic [ID_WIDTH-1:0]  new_owner;
    logic [TMR_W-1:0]     new_timer;
    status_t              status;
    seat_state_t          resp_state_c;
    logic [ID_WIDTH-1:0]  resp_owner_c;

    assign bus.req_ready = !reset && (!bus.resp_valid || bus.resp_ready);
    assign accept        = bus.req_valid && bus.req_ready;
    assign seat_ok       = {1'b0, bus.req_seat} < SEAT_LIM;
    assign sel           = seat_ok ? bus.req_seat : '0;
    assign cur_state     = state_q[sel];
    assign cur_owner     = owner_q[sel];
    assign owner_match   = cur_owner == bus.req_student;

`ifdef SEAT_FORCE_EN
    assign op_legal = bus.req_op != OP_RSVD;
`else
    assign op_legal = bus.req_op < OP_FORCE;
`endif

    always_comb begin
        owns_any = 1'b0;
        for (int i = 0; i < NUM_SEATS; i++)
            if (state_q[i] != EMPTY && owner_q[i] == bus.req_student) owns_any = 1'b1;
    end

    // Command decode: error priority is op, seat range, same-cycle expiry, then per-op rules.
    always_comb begin
        status    = ST_OK;
        wr        = 1'b0;
        new_state = cur_state;
        new_owner = cur_owner;
        new_timer = '0;
        if (!op_legal)            status = ST_ERR_OP;
        else if (!seat_ok)        status = ST_ERR_SEAT;
        else if (expiring[sel])   status = ST_ERR_BUSY;
        else begin
            unique case (bus.req_op)
                OP_RESERVE: begin
                    if (cur_state != EMPTY) status = ST_ERR_STATE;
                    else if (owns_any)      status = ST_ERR_OWNER;
                    else begin
                        wr = 1'b1; new_state = RESERVED; new_owner = bus.req_student; new_timer = RES_T;
                    end
                end
                OP_CHECKIN: begin
                    if (cur_state != RESERVED) status = ST_ERR_STATE;
                    else if (!owner_match)     status = ST_ERR_OWNER;
                    else begin wr = 1'b1; new_state = OCCUPIED; end
                end
                OP_AWAY: begin
                    if (cur_state != OCCUPIED) status = ST_ERR_STATE;
                    else if (!owner_match)     status = ST_ERR_OWNER;
                    else begin wr = 1'b1; new_state = AWAY; new_timer = AWAY_T; end
                end
                OP_RETURN: begin
                    if (cur_state != AWAY)  status = ST_ERR_STATE;
                    else if (!owner_match)  status = ST_ERR_OWNER;
                    else begin wr = 1'b1; new_state = OCCUPIED; end
                end
                OP_RELEASE: begin
                    if (cur_state == EMPTY) status = ST_ERR_STATE;
                    else if (!owner_match)  status = ST_ERR_OWNER;
                    else begin wr = 1'b1; new_state = EMPTY; new_owner = '0; end
                end
                OP_QUERY: status = ST_OK;
`ifdef SEAT_FORCE_EN
                OP_FORCE: begin wr = 1'b1; new_state = EMPTY; new_owner = '0; end
`endif
                default: status = ST_ERR_OP;
            endcase
        end
    end

    // Tick countdown first; an accepted successful command then overrides its own seat.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        timer_d    = timer_q;
        expiring   = '0;
        expire_any = 1'b0;
        for (int i = 0; i < NUM_SEATS; i++) begin
            if (tick && (state_q[i] == RESERVED || state_q[i] == AWAY) && timer_q[i] != '0) begin
                timer_d[i] = timer_q[i] - TMR_W'(1);
                if (timer_q[i] == TMR_W'(1)) begin
                    state_d[i]  = EMPTY;
                    owner_d[i]  = '0;
                    expiring[i] = 1'b1;
                    expire_any  = 1'b1;
                end
            end
        end
        if (accept && wr) begin
            state_d[sel] = new_state;
            owner_d[sel] = new_owner;
            timer_d[sel] = new_timer;
        end
    end

    always_comb begin
        resp_state_c = EMPTY;
        resp_owner_c = '0;
        if (seat_ok && !expiring[sel]) begin
            resp_state_c = wr ? new_state : cur_state;
            resp_owner_c = wr ? new_owner : cur_owner;
        end
    end

    always_comb begin
        occupied_count = '0;
        for (int i = 0; i < NUM_SEATS; i++)
            if (state_q[i] != EMPTY) occupied_count = occupied_count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SEATS; i++) begin
                state_q[i] <= EMPTY;
                owner_q[i] <= '0;
                timer_q[i] <= '0;
            end
            bus.resp_valid  <= 1'b0;
            bus.resp_status <= '0;
            bus.resp_state  <= '0;
            bus.resp_owner  <= '0;
            expire_valid    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            timer_q      <= timer_d;
            expire_valid <= expire_any;
            if (accept) begin
                bus.resp_valid  <= 1'b1;
                bus.resp_status <= status;
                bus.resp_state  <= resp_state_c;
                bus.resp_owner  <= resp_owner_c;
            end else if (bus.resp_ready) begin
                bus.resp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seat_manager.sv
// Bench for seat_manager: directed scenarios with literal expectations, then random traffic against a seat-table model.
// Uses 24 seats so that a 5-bit seat index can address out-of-range seats.
module tb_seat_manager;
  localparam int NS  = 24;
  localparam int IDW = 25;
  localparam int RT  = 10;
  localparam int AT  = 20;
  localparam int SW  = $clog2(NS);
`ifdef SEAT_FORCE_EN
  localparam bit FORCE_EN = 1'b1;
`else
  localparam bit FORCE_EN = 1'b0;
`endif

  logic clk, reset, tick, expire_valid;
  logic [$clog2(NS+1)-1:0] occupied_count;
  int tests = 0, fails = 0;
  bit check_en = 0;

  seat_manager_if #(.NUM_SEATS(NS), .ID_WIDTH(IDW)) bus ();

  seat_manager #(.NUM_SEATS(NS), .ID_WIDTH(IDW), .RESERVE_TIMEOUT(RT), .AWAY_TIMEOUT(AT)) dut (
    .clk(clk), .reset(reset), .tick(tick), .bus(bus.slave),
    .expire_valid(expire_valid), .occupied_count(occupied_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_st [NS];          // 0 empty, 1 reserved, 2 away, 3 occupied
  logic [IDW-1:0] m_own [NS];
  int m_tmr [NS];         // ticks left before a reserved/away seat is freed
  bit m_rv, m_exp;
  int m_rstatus, m_rstate;
  logic [IDW-1:0] m_rowner;

  task automatic model_step();
    bit exp_s [NS];
    bit acc, any_exp, wr, owns, vs;
    int s, st, nst, ntm;
    logic [IDW-1:0] nown;
    any_exp = 0; wr = 0; st = 0; nst = 0; ntm = 0; nown = '0; s = 0; vs = 0;
    if (reset) begin
      for (int i = 0; i < NS; i++) begin m_st[i] = 0; m_own[i] = '0; m_tmr[i] = 0; end
      m_rv = 0; m_rstatus = 0; m_rstate = 0; m_rowner = '0; m_exp = 0;
      return;
    end
    acc = bus.req_valid && (!m_rv || bus.resp_ready);
    for (int i = 0; i < NS; i++)
      exp_s[i] = tick && (m_st[i] == 1 || m_st[i] == 2) && m_tmr[i] == 1;
    if (acc) begin
      s = int'(bus.req_seat);
      vs = s < NS;
      owns = 0;
      for (int i = 0; i < NS; i++) if (m_st[i] != 0 && m_own[i] == bus.req_student) owns = 1;
      if (bus.req_op == 7 || (bus.req_op == 6 && !FORCE_EN)) st = 5;
      else if (!vs) st = 1;
      else if (exp_s[s]) st = 4;
      else begin
        case (bus.req_op)
          0: if (m_st[s] != 0) st = 2; else if (owns) st = 3;
             else begin wr = 1; nst = 1; nown = bus.req_student; ntm = RT; end
          1: if (m_st[s] != 1) st = 2; else if (m_own[s] != bus.req_student) st = 3;
             else begin wr = 1; nst = 3; nown = m_own[s]; end
          2: if (m_st[s] != 3) st = 2; else if (m_own[s] != bus.req_student) st = 3;
             else begin wr = 1; nst = 2; nown = m_own[s]; ntm = AT; end
          3: if (m_st[s] != 2) st = 2; else if (m_own[s] != bus.req_student) st = 3;
             else begin wr = 1; nst = 3; nown = m_own[s]; end
          4: if (m_st[s] == 0) st = 2; else if (m_own[s] != bus.req_student) st = 3;
             else wr = 1;
          6: wr = 1;
          default: st = 0;
        endcase
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (tick && (m_st[i] == 1 || m_st[i] == 2) && m_tmr[i] != 0) begin
        m_tmr[i]--;
        if (m_tmr[i] == 0) begin m_st[i] = 0; m_own[i] = '0; end
      end
      any_exp |= exp_s[i];
    end
    if (acc && wr) begin m_st[s] = nst; m_own[s] = nown; m_tmr[s] = ntm; end
    if (acc) begin
      m_rv = 1; m_rstatus = st;
      m_rstate = vs ? m_st[s] : 0;
      m_rowner = vs ? m_own[s] : '0;
    end else if (bus.resp_ready) m_rv = 0;
    m_exp = any_exp;
  endtask

  always @(posedge clk) model_step();

  function automatic int model_occ();
    int n = 0;
    for (int i = 0; i < NS; i++) if (m_st[i] != 0) n++;
    return n;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("req_ready", bus.req_ready, !reset && (!m_rv || bus.resp_ready));
      chk("resp_valid", bus.resp_valid, m_rv);
      if (m_rv) begin
        chk("resp_status", bus.resp_status, m_rstatus);
        chk("resp_state", bus.resp_state, m_rstate);
        chk("resp_owner", bus.resp_owner, m_rowner);
      end
      chk("expire_valid", expire_valid, m_exp);
      chk("occupied_count", occupied_count, model_occ());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_cmd(input logic [2:0] op, input logic [IDW-1:0] stu, input logic [SW-1:0] seat,
                        input bit with_tick, output logic [2:0] rs, output logic [1:0] rst,
                        output logic [IDW-1:0] ro);
    int n = 0;
    rs = 'x; rst = 'x; ro = 'x;
    @(posedge clk) #1;
    bus.req_valid = 1; bus.req_op = op; bus.req_student = stu; bus.req_seat = seat;
    bus.resp_ready = 1; tick = with_tick;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
      if (n > 50) begin
        tests++; fails++;
        $display("FAIL cmd_accept_timeout: req_ready stayed 0, needed 1");
        bus.req_valid = 0; tick = 0;
        return;
      end
    end
    @(posedge clk) #1;
    bus.req_valid = 0; tick = 0;
    @(negedge clk);
    chk("cmd_resp_valid", bus.resp_valid, 1'b1);
    rs = bus.resp_status; rst = bus.resp_state; ro = bus.resp_owner;
  endtask

  task automatic tick_once(output logic ex, output logic [$clog2(NS+1)-1:0] occ);
    @(posedge clk) #1 tick = 1;
    @(posedge clk) #1 tick = 0;
    @(negedge clk);
    ex = expire_valid; occ = occupied_count;
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] rs;
  logic [1:0] rst;
  logic [IDW-1:0] ro;
  logic ex;
  logic [$clog2(NS+1)-1:0] occ;
  logic [IDW-1:0] pool [4];
  bit rdy;

  initial begin
    pool[0] = 25'h1FFFFFF; pool[1] = 25'h1EC10F3; pool[2] = 25'h00ABCDE; pool[3] = 25'h0;
    reset = 1; tick = 0;
    bus.req_valid = 0; bus.req_op = 0; bus.req_student = '0; bus.req_seat = '0; bus.resp_ready = 1;
    @(posedge clk) #1 check_en = 1;
    tick = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_occupied", occupied_count, 0);
    chk("rst_expire", expire_valid, 1'b0);
    @(posedge clk) #1 reset = 0; tick = 0;

    do_cmd(3'd0, 25'h1FFFFFF, 5'd1, 0, rs, rst, ro);
    chk("reserve1_status", rs, 0); chk("reserve1_state", rst, 1); chk("reserve1_owner", ro, 25'h1FFFFFF);
    chk("reserve1_occ", occupied_count, 1);
    do_cmd(3'd0, 25'h1FFFFFF, 5'd2, 0, rs, rst, ro);
    chk("second_seat_status", rs, 3); chk("second_seat_state", rst, 0); chk("second_seat_owner", ro, 0);
    do_cmd(3'd1, 25'h0000123, 5'd1, 0, rs, rst, ro);
    chk("checkin_wrong_id", rs, 3); chk("checkin_wrong_id_state", rst, 1);
    do_cmd(3'd1, 25'h1FFFFFF, 5'd1, 0, rs, rst, ro);
    chk("checkin_status", rs, 0); chk("checkin_state", rst, 3);
    do_cmd(3'd2, 25'h1FFFFFF, 5'd1, 0, rs, rst, ro);
    chk("away_status", rs, 0); chk("away_state", rst, 2);
    for (int k = 0; k < 5; k++) begin
      tick_once(ex, occ);
      chk("away_no_expire", ex, 1'b0);
    end
    do_cmd(3'd3, 25'h1FFFFFF, 5'd1, 0, rs, rst, ro);
    chk("return_status", rs, 0); chk("return_state", rst, 3); chk("return_owner", ro, 25'h1FFFFFF);

    do_cmd(3'd0, 25'h1EC10F3, 5'd5, 0, rs, rst, ro);
    chk("reserve5_status", rs, 0); chk("reserve5_occ", occupied_count, 2);
    for (int k = 1; k <= RT; k++) begin
      tick_once(ex, occ);
      chk((k == RT) ? "timeout_expire" : "timeout_early", ex, k == RT);
    end
    chk("timeout_occ", occ, 1);
    do_cmd(3'd5, 25'h0, 5'd5, 0, rs, rst, ro);
    chk("timeout_query_state", rst, 0); chk("timeout_query_owner", ro, 0);

    do_cmd(3'd0, 25'h00ABCDE, 5'd9, 0, rs, rst, ro);
    for (int k = 1; k < RT; k++) tick_once(ex, occ);
    do_cmd(3'd1, 25'h00ABCDE, 5'd9, 1, rs, rst, ro);
    chk("busy_status", rs, 4); chk("busy_state", rst, 0); chk("busy_owner", ro, 0);

    // backpressure: first command fills the response slot, second waits
    @(posedge clk) #1;
    bus.resp_ready = 0; bus.req_valid = 1; bus.req_op = 3'd5; bus.req_seat = 5'd1; bus.req_student = '0;
    @(negedge clk) chk("bp_first_ready", bus.req_ready, 1'b1);
    @(posedge clk) #1;
    bus.req_op = 3'd0; bus.req_seat = 5'd7; bus.req_student = 25'h0001234;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_blocked_ready", bus.req_ready, 1'b0);
      chk("bp_hold_state", bus.resp_state, 3);
      chk("bp_hold_owner", bus.resp_owner, 25'h1FFFFFF);
    end
    @(posedge clk) #1 bus.resp_ready = 1;
    @(negedge clk) chk("bp_skid_ready", bus.req_ready, 1'b1);
    @(posedge clk) #1 bus.req_valid = 0;
    @(negedge clk);
    chk("bp_second_status", bus.resp_status, 0);
    chk("bp_second_state", bus.resp_state, 1);
    chk("bp_second_owner", bus.resp_owner, 25'h0001234);

    do_cmd(3'd0, 25'h0000777, 5'd30, 0, rs, rst, ro);
    chk("bad_seat_status", rs, 1); chk("bad_seat_state", rst, 0);
    do_cmd(3'd6, 25'h0000005, 5'd7, 0, rs, rst, ro);
    chk("force_status", rs, FORCE_EN ? 0 : 5);
    chk("force_state", rst, FORCE_EN ? 0 : 1);
    chk("force_owner", ro, FORCE_EN ? 25'h0 : 25'h0001234);
    do_cmd(3'd7, 25'h0000005, 5'd7, 0, rs, rst, ro);
    chk("op7_status", rs, 5);

    // random traffic checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk) rdy = bus.req_ready;
      @(posedge clk) #1;
      reset = ($urandom_range(0, 299) == 0);
      tick = ($urandom_range(0, 2) == 0);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      if (!bus.req_valid || rdy || reset) begin
        bus.req_valid = ($urandom_range(0, 2) != 0);
        bus.req_op = 3'($urandom_range(0, 7));
        bus.req_student = pool[$urandom_range(0, 3)];
        bus.req_seat = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(NS, 31)) : 5'($urandom_range(0, 9));
      end
    end
    @(posedge clk) #1;
    reset = 0; tick = 0; bus.req_valid = 0; bus.resp_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk) check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
